branch_check_queue: RTL
=======================

# branch_check_queue

In-order queue of in-flight branch predictions between fetch and the Memory stage. Fetch pushes up to two predicted branches per cycle (PC, predicted direction, predicted target). The Memory stage pops them in order with actual outcomes. The block compares each outcome against its prediction, drives the predictor update bus (`branch1/2`, `branch_taken1/2`, `pcM1/2`, `targetM1/2`), and raises a one-cycle mispredict redirect that flushes all younger entries.

## Interface
- `DEPTH`, 8: queue entries, power of two, ≥4.
- `PCW`, 9: PC/target width.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `enq_valid1`, `enq_valid2`  in  1  push slot 1 / slot 2 (slot 2 is older-after-slot-1).
- `enq_pc1`, `enq_pc2`  in  PCW  branch PC.
- `enq_pred1`, `enq_pred2`  in  1  predicted taken.
- `enq_target1`, `enq_target2`  in  PCW  predicted target.
- `enq_ready`  out  1  at least two free entries.
- `res_valid1`, `res_valid2`  in  1  resolve head / head+1.
- `res_taken1`, `res_taken2`  in  1  actual direction.
- `res_target1`, `res_target2`  in  PCW  actual target.
- `branch1`, `branch2`  out  1  update strobes to predictor.
- `branch_taken1`, `branch_taken2`  out  1  actual direction.
- `pcM1`, `pcM2`  out  PCW  PC of the resolved branch.
- `targetM1`, `targetM2`  out  PCW  actual target.
- `mispredict`  out  1  redirect strobe.
- `redirect_pc`  out  PCW  correct next PC.
- `count`  out  $clog2(DEPTH)+1  occupancy.
- `overflow`, `underflow`  out  1  sticky error flags.

## Operation
- Circular buffer. Each entry holds {pc, pred, target}. Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Enqueue:
  - Valid slots are packed. If only `enq_valid2` is set, it goes into the tail entry.
  - When both are set, slot 1 goes to the tail and slot 2 to tail+1.
- `enq_ready` = (DEPTH − count) ≥ 2, computed combinationally from registered count.
- Enqueue with insufficient room:
  - Entries that do not fit are dropped.
  - `overflow` sets and stays set until reset.
- Resolve:
  - `res_valid1` pops the head. `res_valid2` pops the next entry.
  - `res_valid2` without `res_valid1` is treated as resolving the head.
- Resolving more entries than are present sets `underflow`. The missing pops are ignored.
- Mispredict test per resolved entry: `res_taken ≠ pred`, OR (`res_taken` AND `res_target ≠ target`).
- Correct next PC: `redirect_pc` = `res_taken` ? `res_target` : pc + 1, computed modulo 2^PCW.
- If entry 1 mispredicts:
  - Entry 2's resolution is discarded.
  - `branch2` = 0.
  - The whole queue flushes: head = tail, count = 0.
- If only entry 2 mispredicts:
  - Both entries update the predictor.
  - The queue flushes.
- Simultaneous enqueue and flush: flush wins and same-cycle enqueues are discarded (wrong path).
- Simultaneous enqueue and non-flushing resolve: both apply, and count = count + pushes − pops.
- Update bus:
  - `branchN` = 1 for each accepted resolution.
  - `branch_takenN`, `targetMN` come from the resolve inputs; `pcMN` comes from the stored entry.

## Timing
- All outputs except `enq_ready` are registered.
- Resolution at edge N produces the update bus, `mispredict` and `redirect_pc` valid during cycle N+1, each lasting exactly one cycle.
- An entry enqueued at edge N can be resolved at edge N+1 or later.
- Reset values:
  - count 0, pointers 0.
  - All strobes 0; `pcM*`, `targetM*`, `redirect_pc` 0.
  - `overflow` 0, `underflow` 0.
  - `enq_ready` 1.
- Reset asserted mid-operation discards all entries at that edge. No update is emitted for them.
- Flush takes effect at the same edge as the mispredicting resolve. Fetch must not enqueue wrong-path entries after `mispredict`, since the block cannot tell them apart.

## Structure
- The shared package holds:
  - The entry struct {pc, pred, target}.
  - The `PCW` default.
  - A `mispredicted(entry, taken, target)` function, reused by the pipeline hazard logic.
- Natural sub-module: `bcq_compare`, a combinational per-slot comparator producing the mispredict flag and the correct next PC. Instantiate it twice.
- Storage is a plain register array, not memory IP.

## Test plan
- Push pc=5 pred=1 tgt=20; resolve taken tgt=20 -> next cycle `branch1`=1, `pcM1`=5, `targetM1`=20, `mispredict`=0, count=0.
- Push pc=5 pred=0; resolve taken tgt=30 -> `mispredict`=1, `redirect_pc`=30.
- Push pc=511 pred=1 tgt=40; resolve not-taken -> `mispredict`=1, `redirect_pc`=0 (wrap).
- Push pcs 3, 4, 7, 8 (count=4); resolve pc3 mispredict with `res_valid2`=1 -> only `branch1`=1, count=0.
- Same resolve with a concurrent dual push -> count=0, `overflow`=0.
- Fill a DEPTH=8 queue to 7 -> `enq_ready`=0. Push two -> one stored, count=8, `overflow`=1.
- Resolve while empty -> `underflow`=1, no strobes.
- Assert `reset` mid-fill with count=5 -> count=0, strobes 0, flags cleared next cycle.

Source files
------------

// File: rtl/branch_check_queue_pkg.sv
// Shared types and helpers for the in-flight branch check queue.
// The mispredict rule is kept here so that hazard logic elsewhere applies the same test.
package branch_check_queue_pkg;

  localparam int BCQ_PCW = 9;

  typedef struct packed {
    logic [BCQ_PCW-1:0] pc;
    logic               pred;
    logic [BCQ_PCW-1:0] target;
  } bcq_entry_t;

  // A not-taken prediction carries no meaningful target, so the target only matters when taken.
  function automatic logic mispredicted(bcq_entry_t e, logic taken, logic [BCQ_PCW-1:0] target);
    return (taken != e.pred) || (taken && (target != e.target));
  endfunction

endpackage

// File: rtl/branch_check_queue_compare.sv
// Per-slot comparator: flags a mispredict and computes the correct next fetch PC.
module bcq_compare
  import branch_check_queue_pkg::*;
(
  input  bcq_entry_t         i_entry,
  input  logic               i_taken,
  input  logic [BCQ_PCW-1:0] i_target,
  output logic               o_mis,
  output logic [BCQ_PCW-1:0] o_next_pc
);

  assign o_mis     = mispredicted(i_entry, i_taken, i_target);
  assign o_next_pc = i_taken ? i_target : i_entry.pc + BCQ_PCW'(1);

endmodule

// File: rtl/branch_check_queue.sv
// In-order queue of predicted branches; resolves up to two per cycle from the head,
// drives the predictor update bus and flushes everything on a mispredict.
module branch_check_queue
  import branch_check_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PCW   = BCQ_PCW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_valid1,
  input  logic                     enq_valid2,
  input  logic [PCW-1:0]           enq_pc1,
  input  logic [PCW-1:0]           enq_pc2,
  input  logic                     enq_pred1,
  input  logic                     enq_pred2,
  input  logic [PCW-1:0]           enq_target1,
  input  logic [PCW-1:0]           enq_target2,
  output logic                     enq_ready,
  input  logic                     res_valid1,
  input  logic                     res_valid2,
  input  logic                     res_taken1,
  input  logic                     res_taken2,
  input  logic [PCW-1:0]           res_target1,
  input  logic [PCW-1:0]           res_target2,
  output logic                     branch1,
  output logic                     branch2,
  output logic                     branch_taken1,
  output logic                     branch_taken2,
  output logic [PCW-1:0]           pcM1,
  output logic [PCW-1:0]           pcM2,
  output logic [PCW-1:0]           targetM1,
  output logic [PCW-1:0]           targetM2,
  output logic                     mispredict,
  output logic [PCW-1:0]           redirect_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  bcq_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [AW:0]   r_count;

  logic [AW:0]   w_free, w_nreq, w_nacc, w_npops;
  logic [AW-1:0] w_head1, w_tail1;
  logic          w_rv1, w_rv2, w_tk1, w_pop1, w_pop2, w_under, w_over;
  logic [PCW-1:0] w_tg1;
  logic          w_c1_mis, w_c2_mis, w_mis1, w_acc2, w_mis2, w_flush;
  logic [PCW-1:0] w_c1_npc, w_c2_npc;
  bcq_entry_t    w_e1, w_e2, w_d1, w_d2;

  assign count     = r_count;
  assign w_free    = DEPTH_C - r_count;
  assign enq_ready = w_free >= (AW+1)'(2);

  // A lone res_valid2 still resolves the head, using the slot-2 outcome.
  assign w_rv1   = res_valid1 | res_valid2;
  assign w_rv2   = res_valid1 & res_valid2;
  assign w_tk1   = res_valid1 ? res_taken1  : res_taken2;
  assign w_tg1   = res_valid1 ? res_target1 : res_target2;
  assign w_pop1  = w_rv1 && (r_count != '0);
  assign w_pop2  = w_rv2 && (r_count >= (AW+1)'(2));
  assign w_under = (w_rv1 && !w_pop1) || (w_rv2 && !w_pop2);

  assign w_head1 = r_head + AW'(1);
  assign w_tail1 = r_tail + AW'(1);
  assign w_e1    = r_mem[r_head];
  assign w_e2    = r_mem[w_head1];

  bcq_compare u_cmp1 (.i_entry(w_e1), .i_taken(w_tk1), .i_target(w_tg1),
                      .o_mis(w_c1_mis), .o_next_pc(w_c1_npc));
  bcq_compare u_cmp2 (.i_entry(w_e2), .i_taken(res_taken2), .i_target(res_target2),
                      .o_mis(w_c2_mis), .o_next_pc(w_c2_npc));

  assign w_mis1  = w_pop1 & w_c1_mis;
  assign w_acc2  = w_pop2 & ~w_mis1;
  assign w_mis2  = w_acc2 & w_c2_mis;
  assign w_flush = w_mis1 | w_mis2;
  assign w_npops = (AW+1)'(w_pop1) + (AW+1)'(w_acc2);

  // Room is judged on the registered count; same-cycle pops do not make extra space.
  assign w_nreq  = (AW+1)'(enq_valid1) + (AW+1)'(enq_valid2);
  assign w_over  = w_nreq > w_free;
  assign w_nacc  = w_over ? w_free : w_nreq;

  always_comb begin
    w_d2 = '{pc: enq_pc2, pred: enq_pred2, target: enq_target2};
    w_d1 = '{pc: enq_pc1, pred: enq_pred1, target: enq_target1};
    if (!enq_valid1) w_d1 = w_d2;
  end

  always_ff @(posedge clk) begin
    if (!reset && !w_flush) begin
      if (w_nacc != '0)             r_mem[r_tail]  <= w_d1;
      if (w_nacc == (AW+1)'(2))     r_mem[w_tail1] <= w_d2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      branch1       <= 1'b0;
      branch2       <= 1'b0;
      branch_taken1 <= 1'b0;
      branch_taken2 <= 1'b0;
      pcM1          <= '0;
      pcM2          <= '0;
      targetM1      <= '0;
      targetM2      <= '0;
      mispredict    <= 1'b0;
      redirect_pc   <= '0;
    end else begin
      if (w_flush) begin
        r_head  <= r_tail;
        r_count <= '0;
      end else begin
        r_head  <= r_head + w_npops[AW-1:0];
        r_tail  <= r_tail + w_nacc[AW-1:0];
        r_count <= r_count + w_nacc - w_npops;
      end
      overflow      <= overflow  | w_over;
      underflow     <= underflow | w_under;
      branch1       <= w_pop1;
      branch2       <= w_acc2;
      branch_taken1 <= w_pop1 & w_tk1;
      branch_taken2 <= w_acc2 & res_taken2;
      pcM1          <= w_pop1 ? w_e1.pc     : '0;
      pcM2          <= w_acc2 ? w_e2.pc     : '0;
      targetM1      <= w_pop1 ? w_tg1       : '0;
      targetM2      <= w_acc2 ? res_target2 : '0;
      mispredict    <= w_flush;
      redirect_pc   <= w_mis1 ? w_c1_npc : (w_mis2 ? w_c2_npc : '0);
    end
  end

endmodule
